// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared FSM encoding and default parameters for seq_detect_prog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DETECT = 2'd2
    } state_t;

    localparam int C_MAX_LEN_DEF = 8;
    localparam int C_LEN_W_DEF   = 4;
    localparam int C_CNT_W_DEF   = 8;

endpackage

`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
// ============================================================================
// Module   : seq_det_sat_cnt
// Purpose  : Saturating up-counter with synchronous clear (clear has priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/seq_detect_prog.sv
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Runtime-programmable serial pattern detector with match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = C_MAX_LEN_DEF,
    parameter int                 LEN_W       = C_LEN_W_DEF,
    parameter int                 CNT_W       = C_CNT_W_DEF,
    parameter logic [MAX_LEN-1:0] PATTERN_RST = MAX_LEN'(4'b0110),
    parameter logic [LEN_W-1:0]   LEN_RST     = LEN_W'(4),
    parameter logic               OVL_RST     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               data,
    input  logic               data_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err,
    output logic               armed
);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic               w_accept;
    logic               w_cfg_ok;
    logic [MAX_LEN-1:0] w_hist_nx;
    logic [LEN_W-1:0]   w_fill_nx;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;

    always_comb begin
        w_accept  = enable & data_valid & ~cfg_we;
        w_cfg_ok  = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        w_hist_nx = {hist_q[MAX_LEN-2:0], data};
        w_fill_nx = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        w_mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < len_q);
        end
        // fill gates the compare, so stale history from before a clear never matches
        w_hit = w_accept && (w_fill_nx >= len_q)
                && (((w_hist_nx ^ pattern_q) & w_mask) == '0);
    end

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        match_d = 1'b0;
        err_d   = 1'b0;

        if (w_accept) begin
            hist_d  = w_hist_nx;
            fill_d  = (w_hit && !ovl_q) ? '0 : w_fill_nx;
            match_d = w_hit;
        end

        if (w_cfg_ok) begin
            fill_d = '0;
        end else if (cfg_we) begin
            err_d = 1'b1;
        end

        if (!enable) begin
            fill_d  = '0;
            state_d = S_IDLE;
        end else if (!w_cfg_ok && (fill_d >= len_q)) begin
            state_d = S_DETECT;
        end else begin
            state_d = S_FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN_RST;
            len_q     <= LEN_RST;
            ovl_q     <= OVL_RST;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            err_q   <= err_d;
            if (w_cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                ovl_q     <= cfg_overlap;
            end
        end
    end

    // Counting on match_d keeps match_cnt in step with the match pulse
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (match_d),
        .cnt_o (match_cnt)
    );

    assign match   = match_q;
    assign cfg_err = err_q;
    assign armed   = (state_q == S_DETECT);

endmodule

`default_nettype wire
